// File: rtl/srl_chain_reader.sv
// rtl/srl_chain_reader.sv - read-side controller for a cascaded SRL shift store
//
// Purpose:
//    The producer shifts words into a chain of 32-stage SRL segments. This block
//    tracks the fill level and addresses the oldest stored word. It pops that
//    word into a registered valid/ready output stage. Together the store and
//    the output register form a FIFO that holds DEPTH+1 words.
//
// Ports:
//    CLK      in   1      clock, all state updates on the rising edge
//    RST      in   1      synchronous active-high reset, overrides CE and Q_READY
//    CE       in   1      push strobe; D enters stage 0 when CE && !FULL
//    D        in   WIDTH  push data
//    FULL     out  1      store holds DEPTH entries; pushes are dropped
//    LEVEL    out  CNT_W  entries in the shift store (output register not counted)
//    Q        out  WIDTH  output register data
//    Q_VALID  out  1      Q holds a valid word
//    Q_READY  in   1      consumer takes Q when Q_VALID && Q_READY

module srl_chain_reader #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 64,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CE,
   input  logic [WIDTH-1:0] D,
   output logic             FULL,
   output logic [CNT_W-1:0] LEVEL,
   output logic [WIDTH-1:0] Q,
   output logic             Q_VALID,
   input  logic             Q_READY
);

   localparam int N_SEG = DEPTH / 32;
   localparam int SEG_W = CNT_W - 5;

   // SRL storage. It has no reset, so its contents are only meaningful below LEVEL.
   logic [WIDTH-1:0] srl [N_SEG][32];

   logic             push;
   logic             load;
   logic [CNT_W-1:0] rd_addr;
   logic [SEG_W-1:0] seg_sel;
   logic [4:0]       tap;
   logic [WIDTH-1:0] rd_word;

   assign FULL    = (LEVEL == CNT_W'(DEPTH));
   assign push    = CE && !FULL;
   assign load    = (LEVEL != '0) && (!Q_VALID || Q_READY);

   // The oldest entry sits at stage LEVEL-1. When LEVEL is 0 this wraps to
   // all-ones, but load is gated off in that case, so the value is never used.
   assign rd_addr = LEVEL - CNT_W'(1);
   assign seg_sel = rd_addr[CNT_W-1:5];
   assign tap     = rd_addr[4:0];

   // Shift the whole cascade. Q31 of each segment feeds stage 0 of the next segment.
   always_ff @(posedge CLK) begin
      if (push) begin
         srl[0][0] <= D;
         for (int s = 1; s < N_SEG; s++) begin
            srl[s][0] <= srl[s-1][31];
         end
         for (int s = 0; s < N_SEG; s++) begin
            for (int t = 1; t < 32; t++) begin
               srl[s][t] <= srl[s][t-1];
            end
         end
      end
   end

   // Addressed read taken from the pre-edge contents. A push in the same cycle
   // shifts the chain only after this value has been captured.
   always_comb begin
      rd_word = '0;
      for (int s = 0; s < N_SEG; s++) begin
         if (seg_sel == SEG_W'(s)) begin
            rd_word = srl[s][tap];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         LEVEL   <= '0;
         Q       <= '0;
         Q_VALID <= 1'b0;
      end else begin
         if (push && !load) begin
            LEVEL <= LEVEL + CNT_W'(1);
         end else if (!push && load) begin
            LEVEL <= LEVEL - CNT_W'(1);
         end

         if (load) begin
            Q       <= rd_word;
            Q_VALID <= 1'b1;
         end else if (Q_VALID && Q_READY) begin
            Q_VALID <= 1'b0;
         end
      end
   end

endmodule
